// File: rtl/factor_pkg.sv
// Shared definitions for the factorization quiz round logic:
// state encoding, prime table and default widths.
package factor_pkg;

  localparam int         QW_DEF      = 10;
  localparam logic [1:0] HP_INIT_DEF = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_LOAD   = 3'd2,
    S_WAIT   = 3'd3,
    S_CHECK  = 3'd4,
    S_UPDATE = 3'd5,
    S_SOLVED = 3'd6,
    S_OVER   = 3'd7
  } state_t;

  function automatic logic [4:0] prime_of(input logic [2:0] idx);
    logic [4:0] p;
    case (idx)
      3'd0:    p = 5'd2;
      3'd1:    p = 5'd3;
      3'd2:    p = 5'd5;
      3'd3:    p = 5'd7;
      3'd4:    p = 5'd11;
      3'd5:    p = 5'd13;
      3'd6:    p = 5'd17;
      default: p = 5'd19;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/factor_div_check.sv
// Repeated-subtraction divider: one subtraction per cycle, then a final
// cycle that reports divisibility. A new start always restarts it.
module factor_div_check
  import factor_pkg::*;
#(
  parameter int QW = QW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [QW-1:0] dividend,
  input  logic [4:0]    divisor,
  output logic          done,
  output logic          divisible,
  output logic [QW-1:0] quot
);

  logic [QW-1:0] rem_reg;
  logic [QW-1:0] quot_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          divisible_reg;
  logic [QW-1:0] divisor_ext;

  assign divisor_ext = {{(QW-5){1'b0}}, divisor};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg       <= '0;
      quot_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      divisible_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        rem_reg       <= dividend;
        quot_reg      <= '0;
        busy_reg      <= 1'b1;
        divisible_reg <= 1'b0;
      end else if (busy_reg) begin
        // A zero divisor falls straight through to "not divisible".
        if (divisor != 5'd0 && rem_reg >= divisor_ext) begin
          rem_reg  <= rem_reg - divisor_ext;
          quot_reg <= quot_reg + 1'b1;
        end else begin
          busy_reg      <= 1'b0;
          done_reg      <= 1'b1;
          divisible_reg <= (rem_reg == '0);
        end
      end
    end
  end

  assign done      = done_reg;
  assign divisible = divisible_reg;
  assign quot      = quot_reg;

endmodule

// File: rtl/factor_round_ctrl.sv
// Round sequencer for the factorization quiz: fetches a question, checks
// player-selected primes against the running quotient, tracks hit points.
module factor_round_ctrl
  import factor_pkg::*;
#(
  parameter int         QW      = QW_DEF,
  parameter logic [1:0] HP_INIT = HP_INIT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ready,
  input  logic          que,
  input  logic [2:0]    sel,
  input  logic          dec,
  input  logic          clr,
  input  logic [QW-1:0] q_num,
  output logic          q_req,
  output logic [QW-1:0] cur,
  output logic [4:0]    last_p,
  output logic [1:0]    hp,
  output logic [2:0]    state,
  output logic          led,
  output logic          miss
);

  state_t        state_reg;
  logic [QW-1:0] cur_reg;
  logic [4:0]    last_p_reg;
  logic [4:0]    p_reg;
  logic [1:0]    hp_reg;
  logic          led_reg;
  logic          miss_reg;
  logic          q_req_reg;
  logic          refetch_reg;
  logic          start_reg;
  logic          que_d_reg;
  logic          dec_d_reg;

  logic          que_rise;
  logic          dec_rise;
  logic          div_done;
  logic          div_divisible;
  logic [QW-1:0] div_quot;

  assign que_rise = que & ~que_d_reg;
  assign dec_rise = dec & ~dec_d_reg;

  factor_div_check #(.QW(QW)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_reg),
    .dividend  (cur_reg),
    .divisor   (p_reg),
    .done      (div_done),
    .divisible (div_divisible),
    .quot      (div_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cur_reg     <= '0;
      last_p_reg  <= '0;
      p_reg       <= '0;
      hp_reg      <= HP_INIT;
      led_reg     <= 1'b0;
      miss_reg    <= 1'b0;
      q_req_reg   <= 1'b0;
      refetch_reg <= 1'b0;
      start_reg   <= 1'b0;
      que_d_reg   <= 1'b0;
      dec_d_reg   <= 1'b0;
    end else begin
      que_d_reg <= que;
      dec_d_reg <= dec;
      q_req_reg <= 1'b0;
      miss_reg  <= 1'b0;
      start_reg <= 1'b0;
      if (clr) begin
        state_reg   <= S_IDLE;
        hp_reg      <= HP_INIT;
        cur_reg     <= '0;
        last_p_reg  <= '0;
        led_reg     <= 1'b0;
        refetch_reg <= 1'b0;
      end else if (!ready && state_reg != S_IDLE) begin
        state_reg   <= S_IDLE;
        led_reg     <= 1'b0;
        refetch_reg <= 1'b0;
      end else if (!que && state_reg inside {S_LOAD, S_WAIT, S_CHECK, S_UPDATE}) begin
        // Abort: any division still running is left to finish unobserved.
        state_reg   <= S_ARMED;
        refetch_reg <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: if (ready) state_reg <= S_ARMED;
          S_ARMED: begin
            if (que && (que_rise || refetch_reg)) begin
              q_req_reg   <= 1'b1;
              refetch_reg <= 1'b0;
              state_reg   <= S_LOAD;
            end else if (!que) begin
              refetch_reg <= 1'b0;
            end
          end
          S_LOAD: begin
            cur_reg    <= q_num;
            last_p_reg <= '0;
            if (q_num < QW'(2)) begin
              refetch_reg <= 1'b1;
              state_reg   <= S_ARMED;
            end else begin
              state_reg <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (dec_rise) begin
              p_reg     <= prime_of(sel);
              start_reg <= 1'b1;
              state_reg <= S_CHECK;
            end
          end
          S_CHECK: if (div_done) state_reg <= S_UPDATE;
          S_UPDATE: begin
            if (div_divisible) begin
              cur_reg    <= div_quot;
              last_p_reg <= p_reg;
              if (div_quot == QW'(1)) begin
                led_reg   <= 1'b1;
                state_reg <= S_SOLVED;
              end else begin
                state_reg <= S_WAIT;
              end
            end else begin
              miss_reg <= 1'b1;
              // Saturate at zero so a round entered with no HP still ends in OVER.
              if (hp_reg <= 2'd1) begin
                hp_reg    <= 2'd0;
                state_reg <= S_OVER;
              end else begin
                hp_reg    <= hp_reg - 2'd1;
                state_reg <= S_WAIT;
              end
            end
          end
          S_SOLVED: begin
            if (!que) begin
              led_reg   <= 1'b0;
              state_reg <= S_ARMED;
            end
          end
          S_OVER:  hp_reg <= 2'd0;
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign q_req  = q_req_reg;
  assign cur    = cur_reg;
  assign last_p = last_p_reg;
  assign hp     = hp_reg;
  assign state  = state_reg;
  assign led    = led_reg;
  assign miss   = miss_reg;

endmodule

// File: tb/tb_factor_round_ctrl.sv
// Directed bench for factor_round_ctrl: a game-level model tracks the
// quotient, hit points and result; a negedge process compares it each cycle.
module tb_factor_round_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ready;
  logic       que;
  logic [2:0] sel;
  logic       dec;
  logic       clr;
  logic [9:0] q_num;
  logic       q_req;
  logic [9:0] cur;
  logic [4:0] last_p;
  logic [1:0] hp;
  logic [2:0] state;
  logic       led;
  logic       miss;

  int total = 0;
  int bad   = 0;
  int miss_cnt = 0;
  int qreq_cnt = 0;
  bit chk_en = 0;

  int m_cur, m_hp, m_last, m_led, m_state;
  int primes [8] = '{2, 3, 5, 7, 11, 13, 17, 19};

  factor_round_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ready  (ready),
    .que    (que),
    .sel    (sel),
    .dec    (dec),
    .clr    (clr),
    .q_num  (q_num),
    .q_req  (q_req),
    .cur    (cur),
    .last_p (last_p),
    .hp     (hp),
    .state  (state),
    .led    (led),
    .miss   (miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q_req) qreq_cnt++;
    if (miss)  miss_cnt++;
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("cur", int'(cur), m_cur);
      chk("hp", int'(hp), m_hp);
      chk("last_p", int'(last_p), m_last);
      chk("led", int'(led), m_led);
      chk("miss_idle", int'(miss), 0);
    end
  end

  task automatic model_clear;
    m_cur = 0; m_hp = 3; m_last = 0; m_led = 0;
  endtask

  // Start from ARMED: drop QUE, then raise it with the question presented.
  task automatic start_round(input int qv);
    int q0, guard;
    chk_en = 0;
    que = 1'b0;
    tick;
    m_led = 0;
    q_num = 10'(qv);
    q0 = qreq_cnt;
    que = 1'b1;
    guard = 0;
    while (state != 3'd3 && guard < 20) begin
      tick;
      guard++;
    end
    chk("round_wait_state", int'(state), 3);
    chk("round_qreq_pulses", qreq_cnt - q0, 1);
    m_cur = qv; m_last = 0; m_state = 3;
    $display("round start q=%0d cur=%0d state=%0d", qv, cur, state);
    chk_en = 1;
  endtask

  task automatic submit(input int s);
    int p, exp_state, exp_miss, m0, guard;
    chk_en = 0;
    p = primes[s];
    m0 = miss_cnt;
    if (m_state == 7) begin
      exp_state = 7; exp_miss = 0;
    end else if (m_cur % p == 0) begin
      m_cur = m_cur / p; m_last = p; exp_miss = 0;
      if (m_cur == 1) begin m_led = 1; exp_state = 6; end
      else exp_state = 3;
    end else begin
      exp_miss = 1;
      m_hp = (m_hp > 0) ? m_hp - 1 : 0;
      exp_state = (m_hp == 0) ? 7 : 3;
    end
    sel = 3'(s);
    dec = 1'b1;
    tick;
    guard = 0;
    while ((state == 3'd4 || state == 3'd5) && guard < 700) begin
      tick;
      guard++;
    end
    if (guard >= 700) chk("submit_timeout", guard, 0);
    dec = 1'b0;
    tick;
    chk("submit_state", int'(state), exp_state);
    chk("submit_miss", miss_cnt - m0, exp_miss);
    m_state = exp_state;
    $display("submit p=%0d cur=%0d hp=%0d last_p=%0d state=%0d", p, cur, hp, last_p, state);
    chk_en = 1;
  endtask

  task automatic clear_game;
    chk_en = 0;
    clr = 1'b1;
    tick;
    chk("clr_state", int'(state), 0);
    chk("clr_hp", int'(hp), 3);
    chk("clr_cur", int'(cur), 0);
    clr = 1'b0;
    tick;
    chk("clr_rearm", int'(state), 1);
    model_clear();
    m_state = 1;
    $display("clear state=%0d hp=%0d", state, hp);
    chk_en = 1;
  endtask

  initial begin
    int m0, q0;
    rst_n = 1'b0; ready = 1'b0; que = 1'b0; sel = 3'd0;
    dec = 1'b0; clr = 1'b0; q_num = 10'd0;
    model_clear();
    m_state = 0;
    tick; tick;
    chk("rst_state", int'(state), 0);
    chk("rst_cur", int'(cur), 0);
    chk("rst_hp", int'(hp), 3);
    chk("rst_led", int'(led), 0);
    chk("rst_qreq", int'(q_req), 0);
    chk("rst_miss", int'(miss), 0);
    chk("rst_last_p", int'(last_p), 0);
    $display("reset state=%0d hp=%0d", state, hp);
    rst_n = 1'b1;
    tick;
    ready = 1'b1;
    tick;
    chk("armed", int'(state), 1);
    m_state = 1;
    chk_en = 1;

    // Solve 84 = 2*2*3*7
    start_round(84);
    chk("solve_load", int'(cur), 84);
    submit(0); chk("solve_42", int'(cur), 42);
    submit(0); chk("solve_21", int'(cur), 21);
    submit(1); chk("solve_7", int'(cur), 7);
    submit(3);
    chk("solve_cur", int'(cur), 1);
    chk("solve_last_p", int'(last_p), 7);
    chk("solve_led", int'(led), 1);
    chk("solve_hp", int'(hp), 3);
    chk("solve_state", int'(state), 6);

    // Wrong guess on 21
    start_round(21);
    chk("after_solve_led", int'(led), 0);
    submit(0);
    chk("wrong_hp", int'(hp), 2);
    chk("wrong_cur", int'(cur), 21);
    chk("wrong_state", int'(state), 3);

    // Game over from full HP
    clear_game();
    start_round(21);
    submit(0); submit(2); submit(0);
    chk("over_hp", int'(hp), 0);
    chk("over_state", int'(state), 7);
    submit(1);
    chk("over_ignored_state", int'(state), 7);
    chk("over_ignored_cur", int'(cur), 21);
    clear_game();

    // Abort mid-division
    start_round(1020);
    sel = 3'd0;
    dec = 1'b1;
    repeat (5) tick;
    chk("abort_in_check", int'(state), 4);
    m0 = miss_cnt;
    que = 1'b0;
    tick;
    chk("abort_armed", int'(state), 1);
    m_state = 1;
    dec = 1'b0;
    repeat (600) tick;
    chk("abort_no_miss", miss_cnt - m0, 0);
    chk("abort_cur", int'(cur), 1020);
    chk("abort_still_armed", int'(state), 1);
    $display("abort cur=%0d state=%0d", cur, state);

    // Invalid questions re-fetch
    chk_en = 0;
    q0 = qreq_cnt;
    q_num = 10'd1;
    que = 1'b1;
    tick; chk("inv1_load", int'(state), 2); chk("inv1_qreq", int'(q_req), 1);
    tick; chk("inv1_armed", int'(state), 1); chk("inv1_cur", int'(cur), 1);
    chk("inv1_qreq_low", int'(q_req), 0);
    q_num = 10'd0;
    tick; chk("inv0_load", int'(state), 2); chk("inv0_qreq", int'(q_req), 1);
    tick; chk("inv0_armed", int'(state), 1); chk("inv0_cur", int'(cur), 0);
    q_num = 10'd84;
    tick; chk("valid_load", int'(state), 2);
    tick; chk("valid_wait", int'(state), 3); chk("valid_cur", int'(cur), 84);
    chk("inv_qreq_pulses", qreq_cnt - q0, 3);
    $display("refetch q_req pulses=%0d cur=%0d", qreq_cnt - q0, cur);
    m_cur = 84; m_last = 0; m_state = 3;
    chk_en = 1;

    // Async reset in the middle of a division
    submit(0);
    chk("pre_rst_last_p", int'(last_p), 2);
    chk_en = 0;
    sel = 3'd0;
    dec = 1'b1;
    tick; tick;
    chk("pre_rst_check", int'(state), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_cur", int'(cur), 0);
    chk("arst_last_p", int'(last_p), 0);
    chk("arst_hp", int'(hp), 3);
    chk("arst_led", int'(led), 0);
    chk("arst_miss", int'(miss), 0);
    chk("arst_qreq", int'(q_req), 0);
    $display("async reset state=%0d cur=%0d", state, cur);
    dec = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
